// File: rtl/vga_sprite_overlay_if.sv
// Video/button bundle between the colour-table stage and the sprite overlay.
// Inputs keep their i* names, composited outputs their o* names.
interface vga_sprite_overlay_if #(parameter int SEL_W = 2);
  logic             iHS, iVS, iBLANK_n;
  logic [23:0]      iBGR;
  logic [SEL_W-1:0] iSel;
  logic             iUp_n, iDown_n, iLeft_n, iRight_n;
  logic             oHS, oVS, oBLANK_n;
  logic [23:0]      oBGR;
  logic             oCollide;

  modport master (output iHS, iVS, iBLANK_n, iBGR, iSel, iUp_n, iDown_n, iLeft_n, iRight_n,
                  input  oHS, oVS, oBLANK_n, oBGR, oCollide);
  modport slave  (input  iHS, iVS, iBLANK_n, iBGR, iSel, iUp_n, iDown_n, iLeft_n, iRight_n,
                  output oHS, oVS, oBLANK_n, oBGR, oCollide);
endinterface

// File: rtl/vga_sprite_overlay.sv
// Multi-sprite overlay: scan tracking, button-driven sprite moves committed at
// vsync, priority compositing and per-frame collision reporting.
module vga_sprite_lane #(
  parameter int IDX      = 0,
  parameter int H_ACT    = 640,
  parameter int V_ACT    = 480,
  parameter int SPR_SIZE = 50,
  parameter int STEP     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       commit_i,
  input  logic [3:0] mv_i,      // {up, down, left, right}
  input  logic [9:0] sx_i,
  input  logic [9:0] sy_i,
  input  logic       blank_n_i,
  output logic       hit_o
);
  localparam logic [9:0]  X_RST = 10'(IDX * (SPR_SIZE + STEP));
  localparam logic [9:0]  Y_RST = 10'((V_ACT - SPR_SIZE) / 2);
  localparam logic [10:0] X_MAX = 11'(H_ACT - SPR_SIZE);
  localparam logic [10:0] Y_MAX = 11'(V_ACT - SPR_SIZE);
  localparam logic [10:0] STP   = 11'(STEP);
  localparam logic [10:0] SZ    = 11'(SPR_SIZE);

  logic [9:0]  x_q, x_d, y_q, y_d;
  logic [10:0] xp, xm, yp, ym;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    xp  = {1'b0, x_q} + STP;
    xm  = {1'b0, x_q} - STP;
    yp  = {1'b0, y_q} + STP;
    ym  = {1'b0, y_q} - STP;
    // bit 10 of the difference flags an underflow past zero
    if (commit_i) begin
      if (mv_i[1] && !mv_i[0]) x_d = xm[10] ? 10'd0 : xm[9:0];
      if (mv_i[0] && !mv_i[1]) x_d = (xp > X_MAX) ? X_MAX[9:0] : xp[9:0];
      if (mv_i[3] && !mv_i[2]) y_d = ym[10] ? 10'd0 : ym[9:0];
      if (mv_i[2] && !mv_i[3]) y_d = (yp > Y_MAX) ? Y_MAX[9:0] : yp[9:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= X_RST;
      y_q <= Y_RST;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign hit_o = blank_n_i
               && ({1'b0, sx_i} >= {1'b0, x_q}) && ({1'b0, sx_i} < {1'b0, x_q} + SZ)
               && ({1'b0, sy_i} >= {1'b0, y_q}) && ({1'b0, sy_i} < {1'b0, y_q} + SZ);
endmodule

module vga_sprite_overlay #(
  parameter int                  H_ACT      = 640,
  parameter int                  V_ACT      = 480,
  parameter int                  SPR_NUM    = 4,
  parameter int                  SPR_SIZE   = 50,
  parameter int                  STEP       = 5,
  parameter logic [24*SPR_NUM-1:0] SPR_COLORS = {SPR_NUM{24'h0000ff}}
) (
  input logic                  iVGA_CLK,
  input logic                  iRST_n,
  vga_sprite_overlay_if.slave  vid
);
  logic             hs_q, vs_q, blank_q, col_q, col_d, flag_q, flag_d;
  logic [23:0]      bgr_q, bgr_d, spr_pix;
  logic [9:0]       sx_q, sx_d, sy_q, sy_d;
  logic [3:0]       b1_q, b2_q, b3_q, press, pend_q, pend_d;
  logic [SPR_NUM-1:0] hit;
  logic             commit, sel_ok, any_hit, multi;

  assign commit = vs_q && !vid.iVS;
  assign sel_ok = int'(vid.iSel) < SPR_NUM;
  assign press  = b3_q & ~b2_q;

  genvar g;
  generate
    for (g = 0; g < SPR_NUM; g++) begin : g_spr
      vga_sprite_lane #(.IDX(g), .H_ACT(H_ACT), .V_ACT(V_ACT),
                        .SPR_SIZE(SPR_SIZE), .STEP(STEP)) u_lane (
        .clk      (iVGA_CLK),
        .rst_n    (iRST_n),
        .commit_i (commit && sel_ok && (int'(vid.iSel) == g)),
        .mv_i     (pend_q),
        .sx_i     (sx_q),
        .sy_i     (sy_q),
        .blank_n_i(vid.iBLANK_n),
        .hit_o    (hit[g])
      );
    end
  endgenerate

  always_comb begin
    any_hit = 1'b0;
    multi   = 1'b0;
    spr_pix = 24'h0;
    for (int i = 0; i < SPR_NUM; i++)
      if (hit[i]) begin
        if (any_hit) multi = 1'b1;
        any_hit = 1'b1;
      end
    // walk downward so the lowest-index sprite ends up on top
    for (int i = SPR_NUM - 1; i >= 0; i--)
      if (hit[i]) spr_pix = SPR_COLORS[24*i +: 24];
    bgr_d = !vid.iBLANK_n ? 24'h0 : (any_hit ? spr_pix : vid.iBGR);

    sx_d = sx_q;
    sy_d = sy_q;
    if (!vid.iVS) begin
      sx_d = 10'd0;
      sy_d = 10'd0;
    end else if (vid.iBLANK_n) begin
      sx_d = sx_q + 10'd1;
    end else if (blank_q) begin
      sx_d = 10'd0;
      sy_d = sy_q + 10'd1;
    end

    pend_d = commit ? press : (pend_q | press);
    flag_d = commit ? 1'b0 : (flag_q | multi);
    col_d  = commit ? (flag_q | multi) : col_q;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
      bgr_q   <= 24'h0;
      col_q   <= 1'b0;
      flag_q  <= 1'b0;
      sx_q    <= 10'd0;
      sy_q    <= 10'd0;
      b1_q    <= 4'hf;
      b2_q    <= 4'hf;
      b3_q    <= 4'hf;
      pend_q  <= 4'h0;
    end else begin
      hs_q    <= vid.iHS;
      vs_q    <= vid.iVS;
      blank_q <= vid.iBLANK_n;
      bgr_q   <= bgr_d;
      col_q   <= col_d;
      flag_q  <= flag_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      b1_q    <= {vid.iUp_n, vid.iDown_n, vid.iLeft_n, vid.iRight_n};
      b2_q    <= b1_q;
      b3_q    <= b2_q;
      pend_q  <= pend_d;
    end
  end

  assign vid.oHS      = hs_q;
  assign vid.oVS      = vs_q;
  assign vid.oBLANK_n = blank_q;
  assign vid.oBGR     = bgr_q;
  assign vid.oCollide = col_q;
endmodule

// File: tb/tb_vga_sprite_overlay.sv
// Directed scan/button stimulus with a cycle-stamped expectation queue drained
// by an independent output monitor.
module tb_vga_sprite_overlay;
  localparam logic [23:0] C0 = 24'h0000ff, C1 = 24'h00ff00, C2 = 24'hff0000, C3 = 24'h00ffff;
  localparam logic [23:0] BG = 24'h123456, BG2 = 24'habcdef;
  localparam int NONE = -1;

  logic clk = 1'b0, rst_n = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0, n_bad = 0;

  vga_sprite_overlay_if #(.SEL_W(2)) vif();

  vga_sprite_overlay #(.H_ACT(640), .V_ACT(480), .SPR_NUM(4), .SPR_SIZE(50), .STEP(5),
                       .SPR_COLORS({C3, C2, C1, C0})) dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .vid(vif));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: oBGR, 1: oCollide, 2: all outputs at reset, 3: {oHS,oVS,oBLANK_n}
  typedef struct { int cyc; int kind; logic [27:0] exp; string nm; } ent_t;
  ent_t q[$];

  task automatic push(input int kind, input logic [27:0] exp, input string nm, input int off = 1);
    ent_t e;
    e.cyc = cyc + off; e.kind = kind; e.exp = exp; e.nm = nm;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      ent_t e;
      logic [27:0] act;
      e = q.pop_front();
      n_cmp++;
      case (e.kind)
        0:       act = {4'h0, vif.oBGR};
        1:       act = {27'h0, vif.oCollide};
        2:       act = {vif.oHS, vif.oVS, vif.oBLANK_n, vif.oCollide, vif.oBGR};
        default: act = {25'h0, vif.oHS, vif.oVS, vif.oBLANK_n};
      endcase
      if (e.cyc < cyc) begin
        n_bad++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.nm, e.cyc, cyc);
      end else if (act !== e.exp) begin
        n_bad++;
        $display("FAIL %s: got %h, want %h", e.nm, act, e.exp);
      end
    end
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      vif.iBLANK_n = 1'b0; vif.iHS = 1'b1; vif.iVS = 1'b1; vif.iBGR = BG2;
    end
  endtask

  task automatic vsync();
    @(posedge clk); #1; vif.iVS = 1'b0; vif.iBLANK_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; vif.iVS = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic chk_col(input logic exp, input string nm);
    @(posedge clk); #1;
    push(1, {27'h0, exp}, nm);
  endtask

  // d: 0 up, 1 down, 2 left, 3 right
  task automatic press(input int d);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      vif.iUp_n    = !(d == 0 && k < 3);
      vif.iDown_n  = !(d == 1 && k < 3);
      vif.iLeft_n  = !(d == 2 && k < 3);
      vif.iRight_n = !(d == 3 && k < 3);
    end
  endtask

  task automatic skip(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1; vif.iBLANK_n = 1'b1; vif.iBGR = BG;
      @(posedge clk); #1; vif.iBLANK_n = 1'b0; vif.iBGR = BG2;
    end
  endtask

  // one active line of n pixels (pixel k at sx=k) with up to three checked pixels,
  // followed by one blanking clock with hsync asserted
  task automatic line(input int n, input int p0, input logic [23:0] e0,
                      input int p1, input logic [23:0] e1,
                      input int p2, input logic [23:0] e2, input string nm);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1; vif.iBLANK_n = 1'b1; vif.iHS = 1'b1; vif.iBGR = BG;
      if (k == p0) push(0, {4'h0, e0}, $sformatf("%s sx=%0d", nm, k));
      if (k == p1) push(0, {4'h0, e1}, $sformatf("%s sx=%0d", nm, k));
      if (k == p2) push(0, {4'h0, e2}, $sformatf("%s sx=%0d", nm, k));
    end
    @(posedge clk); #1; vif.iBLANK_n = 1'b0; vif.iHS = 1'b0; vif.iBGR = BG2;
    push(0, 28'h0, {nm, " blank"});
    push(3, 28'h2, {nm, " sync"});
    @(posedge clk); #1; vif.iHS = 1'b1;
  endtask

  initial begin
    vif.iHS = 1'b1; vif.iVS = 1'b1; vif.iBLANK_n = 1'b0; vif.iBGR = BG2; vif.iSel = 2'd0;
    vif.iUp_n = 1'b1; vif.iDown_n = 1'b1; vif.iLeft_n = 1'b1; vif.iRight_n = 1'b1;
    @(posedge clk); #1;
    push(2, {4'b1100, 24'h0}, "reset outputs", 0);
    @(posedge clk); #1; rst_n = 1'b1;
    tick(2);

    // default layout: sprite i at x=55*i, y=215
    vsync(); chk_col(1'b0, "collide idle");
    skip(215);
    line(60, 0, C0, 50, BG, 55, C1, "t1 default");

    // sprite 1 right by one step
    vif.iSel = 2'd1; press(3); vsync();
    skip(215);
    line(112, 59, BG, 60, C1, 110, C2, "t2 right");
    line(56, 55, BG, NONE, BG, NONE, BG, "t2 row216");

    // sprite 0 clamped at the left edge
    vif.iSel = 2'd0;
    for (int f = 0; f < 3; f++) begin press(2); vsync(); end
    skip(215);
    line(51, 0, C0, 49, C0, 50, BG, "t3 left clamp");

    // sprite 0 driven to the bottom edge, one extra press must not move it
    for (int f = 0; f < 44; f++) begin press(1); vsync(); end
    skip(429);
    line(2, 0, BG, NONE, BG, NONE, BG, "t3 sy429");
    line(2, 0, C0, NONE, BG, NONE, BG, "t3 sy430");
    skip(48);
    line(2, 0, C0, NONE, BG, NONE, BG, "t3 sy479");

    // sprite 3: up+down cancel, then four rights in one frame -> one step
    vif.iSel = 2'd3; press(0); press(1); vsync();
    skip(214);
    line(166, 165, BG, NONE, BG, NONE, BG, "t4 sy214");
    line(166, 164, BG, 165, C3, NONE, BG, "t4 sy215");
    for (int k = 0; k < 4; k++) press(3);
    vsync();
    skip(215);
    line(221, 169, BG, 170, C3, 220, BG, "t4 right x4");

    // sprite 2 left twice onto sprite 1
    vif.iSel = 2'd2; press(2); vsync(); press(2); vsync();
    chk_col(1'b0, "collide before overlap");
    skip(215);
    line(150, 99, C1, 100, C1, 110, C2, "t5 overlap100");
    press(3); vsync(); chk_col(1'b1, "collide set");
    skip(215);
    line(150, 104, C1, 105, C1, 110, C2, "t5 overlap105");
    press(3); vsync(); chk_col(1'b1, "collide still");
    skip(215);
    line(221, 109, C1, 110, C2, 160, BG, "t5 apart");
    vsync(); chk_col(1'b0, "collide cleared");

    // reset in the middle of an active line
    skip(215);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1; vif.iBLANK_n = 1'b1; vif.iBGR = BG;
      if (k == 5) push(0, {4'h0, BG}, "t6 pre-reset pixel");
    end
    @(posedge clk); #1; rst_n = 1'b0;
    push(2, {4'b1100, 24'h0}, "t6 mid-line reset", 0);
    @(posedge clk); #1; vif.iBLANK_n = 1'b0; vif.iBGR = BG2;
    @(posedge clk); #1; rst_n = 1'b1;
    tick(2);
    vsync();
    skip(215);
    line(166, 0, C0, 55, C1, 165, C3, "t6 defaults");
    line(61, 60, C1, 54, BG, NONE, BG, "t6 row216");

    for (int k = 0; k < 20 && q.size() > 0; k++) tick(1);
    if (q.size() > 0) begin
      $display("FAIL drain: %0d expectations never sampled, want 0", q.size());
      n_cmp += q.size(); n_bad += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
